// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU SRAM responder: sequencer states,
// default out-of-range instruction word and boot bank selectors.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [15:0] OOB_INST_DEFAULT = 16'h7000;

  localparam logic BANK_I = 1'b0;
  localparam logic BANK_D = 1'b1;

  // Range check done in 32 bits so DEPTH == 2**ADDR_WIDTH cannot wrap.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One SRAM bank: DEPTH x DATA_WIDTH words, combinational read, one synchronous write port.
module sram_bank #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/cpu_sram_responder.sv
// Memory-side responder for the CPU: clears both banks, loads a boot image,
// then serves instruction fetches and data reads/writes.
module cpu_sram_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4096,
  parameter logic [DATA_WIDTH-1:0] OOB_INST = OOB_INST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  output logic [DATA_WIDTH-1:0] inst_out,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we_n,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_ready,
  input  logic                  boot_valid,
  output logic                  boot_ready,
  input  logic                  boot_sel,
  input  logic [ADDR_WIDTH-1:0] boot_addr,
  input  logic [DATA_WIDTH-1:0] boot_data,
  input  logic                  boot_last,
  output logic                  oob_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [31:0]      DEPTH_W  = 32'(DEPTH);

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        clr_cnt_r;
  logic                    mem_ready_r, boot_ready_r, oob_err_r;
  logic                    addr0_ok_s, addr1_ok_s, boot_ok_s, boot_hs_s;
  logic                    i_we_s, d_we_s;
  logic [IDX_W-1:0]        i_waddr_s, d_waddr_s;
  logic [DATA_WIDTH-1:0]   i_wdata_s, d_wdata_s;
  logic [DATA_WIDTH-1:0]   i_rdata_s, d_rdata_s;

  assign addr0_ok_s = in_range(32'(addr_0), DEPTH_W);
  assign addr1_ok_s = in_range(32'(addr_1), DEPTH_W);
  assign boot_ok_s  = in_range(32'(boot_addr), DEPTH_W);
  assign boot_hs_s  = boot_valid && boot_ready_r;

  // Sequencer next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_IDX) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_LOAD: begin
        if (boot_hs_s && boot_last) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_CLEAR;
    endcase
  end

  // Sequencer state, clear counter, handshake flags and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_CLEAR;
      clr_cnt_r    <= '0;
      mem_ready_r  <= 1'b0;
      boot_ready_r <= 1'b0;
      oob_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      mem_ready_r  <= (state_s == ST_RUN);
      boot_ready_r <= (state_s == ST_LOAD);
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + CNT_W'(1);
      end
      if ((state_r == ST_RUN) && (!addr0_ok_s || (!we_n && !addr1_ok_s))) begin
        oob_err_r <= 1'b1;
      end
    end
  end

  // Write-port arbitration: clear sweep, boot loader or CPU data store.
  always_comb begin
    i_we_s    = 1'b0;
    d_we_s    = 1'b0;
    i_waddr_s = boot_addr[IDX_W-1:0];
    d_waddr_s = boot_addr[IDX_W-1:0];
    i_wdata_s = boot_data;
    d_wdata_s = boot_data;
    case (state_r)
      ST_CLEAR: begin
        i_we_s    = 1'b1;
        d_we_s    = 1'b1;
        i_waddr_s = clr_cnt_r[IDX_W-1:0];
        d_waddr_s = clr_cnt_r[IDX_W-1:0];
        i_wdata_s = '0;
        d_wdata_s = '0;
      end
      ST_LOAD: begin
        if (boot_hs_s && boot_ok_s) begin
          i_we_s = (boot_sel == BANK_I);
          d_we_s = (boot_sel == BANK_D);
        end else begin
          i_we_s = 1'b0;
          d_we_s = 1'b0;
        end
      end
      ST_RUN: begin
        d_we_s    = !we_n && addr1_ok_s;
        d_waddr_s = addr_1[IDX_W-1:0];
        d_wdata_s = wdata;
      end
      default: begin
        i_we_s = 1'b0;
        d_we_s = 1'b0;
      end
    endcase
  end

  sram_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_imem (
    .clk   (clk),
    .we    (i_we_s),
    .waddr (i_waddr_s),
    .wdata (i_wdata_s),
    .raddr (addr_0[IDX_W-1:0]),
    .rdata (i_rdata_s)
  );

  sram_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_dmem (
    .clk   (clk),
    .we    (d_we_s),
    .waddr (d_waddr_s),
    .wdata (d_wdata_s),
    .raddr (addr_1[IDX_W-1:0]),
    .rdata (d_rdata_s)
  );

  // Reads are masked until RUN so the CPU sees no-ops and zero data while booting.
  assign inst_out   = ((state_r == ST_RUN) && addr0_ok_s) ? i_rdata_s : OOB_INST;
  assign rdata      = ((state_r == ST_RUN) && addr1_ok_s) ? d_rdata_s : '0;
  assign mem_ready  = mem_ready_r;
  assign boot_ready = boot_ready_r;
  assign oob_err    = oob_err_r;

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Randomized scoreboard bench for cpu_sram_responder with DEPTH=16 and a
// phase/array reference model of the boot and run behaviour.
module tb_cpu_sram_responder;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int D  = 16;
  localparam int PH_CLEAR = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_RUN   = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] addr_0, addr_1, boot_addr;
  logic [DW-1:0] wdata, boot_data, inst_out, rdata;
  logic          we_n, mem_ready, boot_valid, boot_ready, boot_sel, boot_last, oob_err;

  always #5 clk = ~clk;

  cpu_sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .addr_0(addr_0), .inst_out(inst_out),
    .addr_1(addr_1), .wdata(wdata), .we_n(we_n), .rdata(rdata),
    .mem_ready(mem_ready),
    .boot_valid(boot_valid), .boot_ready(boot_ready), .boot_sel(boot_sel),
    .boot_addr(boot_addr), .boot_data(boot_data), .boot_last(boot_last),
    .oob_err(oob_err)
  );

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] rd;
    logic        mr;
    logic        br;
    logic        oob;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] m_imem [D];
  logic [15:0] m_dmem [D];
  int          m_phase;
  int          m_clear_left;
  logic        m_oob;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents combinational outputs every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst_out", inst_out, e.inst);
      chk("rdata", rdata, e.rd);
      chk("mem_ready", {15'd0, mem_ready}, {15'd0, e.mr});
      chk("boot_ready", {15'd0, boot_ready}, {15'd0, e.br});
      chk("oob_err", {15'd0, oob_err}, {15'd0, e.oob});
    end
  end

  task automatic model_reset();
    m_phase      = PH_CLEAR;
    m_clear_left = D;
    m_oob        = 1'b0;
    for (int i = 0; i < D; i++) begin
      m_imem[i] = 16'h0000;
      m_dmem[i] = 16'h0000;
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.mr   = (m_phase == PH_RUN);
    e.br   = (m_phase == PH_LOAD);
    e.oob  = m_oob;
    e.inst = (m_phase == PH_RUN && addr_0 < D) ? m_imem[addr_0[3:0]] : 16'h7000;
    e.rd   = (m_phase == PH_RUN && addr_1 < D) ? m_dmem[addr_1[3:0]] : 16'h0000;
    return e;
  endfunction

  task automatic model_edge();
    if (m_phase == PH_CLEAR) begin
      m_clear_left--;
      if (m_clear_left == 0) m_phase = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      if (boot_valid) begin
        if (boot_addr < D) begin
          if (boot_sel) m_dmem[boot_addr[3:0]] = boot_data;
          else          m_imem[boot_addr[3:0]] = boot_data;
        end
        if (boot_last) m_phase = PH_RUN;
      end
    end else begin
      if (!we_n && addr_1 < D) m_dmem[addr_1[3:0]] = wdata;
      if (addr_0 >= D || (!we_n && addr_1 >= D)) m_oob = 1'b1;
    end
  endtask

  // One clock: expected outputs for the current inputs, then the edge effect.
  task automatic cycle();
    if (!reset_n) model_reset();
    sb.push_back(model_outputs());
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    addr_0 = 16'hFFFF; addr_1 = 16'h0000; wdata = 16'h0000; we_n = 1'b1;
    boot_valid = 1'b0; boot_sel = 1'b0; boot_addr = 16'h0000;
    boot_data = 16'h0000; boot_last = 1'b0;
  endtask

  task automatic boot_word(input logic sel, input logic [15:0] a, input logic [15:0] d, input logic last);
    boot_valid = 1'b1; boot_sel = sel; boot_addr = a; boot_data = d; boot_last = last;
    cycle();
    boot_valid = 1'b0; boot_last = 1'b0;
  endtask

  task automatic cpu_noise();
    addr_0 = 16'($urandom); addr_1 = 16'($urandom_range(0, 31));
    wdata  = 16'($urandom); we_n   = 1'($urandom);
  endtask

  task automatic random_run(input int n, input int a1_max);
    for (int i = 0; i < n; i++) begin
      addr_0 = 16'($urandom_range(0, D - 1));
      addr_1 = 16'($urandom_range(0, a1_max));
      wdata  = 16'($urandom);
      we_n   = 1'($urandom);
      boot_valid = 1'($urandom); boot_last = 1'($urandom);
      boot_addr  = 16'($urandom_range(0, D - 1)); boot_data = 16'($urandom);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    repeat (3) cycle();
    reset_n = 1'b1;

    // Clearing: boot_valid held and CPU writes attempted, all ignored.
    for (int i = 0; i < D; i++) begin
      boot_valid = 1'b1; boot_sel = 1'($urandom); boot_last = 1'($urandom);
      boot_addr = 16'($urandom_range(0, D - 1)); boot_data = 16'($urandom);
      cpu_noise();
      cycle();
    end
    idle_inputs();

    // Loading: random handshakes, including dropped out-of-range words.
    for (int i = 0; i < 20; i++) begin
      boot_valid = 1'($urandom); boot_sel = 1'($urandom); boot_last = 1'b0;
      boot_addr = 16'($urandom_range(0, 31)); boot_data = 16'($urandom);
      cpu_noise();
      cycle();
    end
    idle_inputs();
    boot_word(1'b0, 16'd0, 16'h2005, 1'b0);
    boot_word(1'b1, 16'd5, 16'h00AA, 1'b1);

    // Run: directed reads, write-then-read, then random traffic.
    addr_0 = 16'd0; addr_1 = 16'd5; boot_valid = 1'b1;
    cycle();
    addr_0 = 16'd3; addr_1 = 16'd3; we_n = 1'b0; wdata = 16'h1234;
    cycle();
    we_n = 1'b1;
    cycle();
    random_run(40, D - 1);

    // Out-of-range data write sets the sticky error.
    addr_0 = 16'd1; addr_1 = 16'd20; we_n = 1'b0; wdata = 16'hDEAD;
    cycle();
    we_n = 1'b1;
    cycle();
    random_run(10, D - 1);

    // Reset mid-LOAD, then reboot with a different image.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    repeat (D) cycle();
    boot_word(1'b0, 16'd0, 16'hBEEF, 1'b0);
    boot_word(1'b1, 16'd5, 16'h5555, 1'b0);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    repeat (D) cycle();
    boot_word(1'b1, 16'd2, 16'h0055, 1'b1);
    addr_0 = 16'd0; addr_1 = 16'd5;
    repeat (2) cycle();
    addr_1 = 16'd2;
    cycle();
    random_run(20, 31);
    addr_0 = 16'hFFFF;
    cycle();
    addr_0 = 16'd0;
    repeat (2) cycle();

    @(negedge clk); #1;
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
